// File: rtl/avr_sdspi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : avr_sdspi_pkg
//  Brief    : Shared constants for the AVR slave-SPI to SD-access register port
//  Revision : 1.0  initial release
// ============================================================================
package avr_sdspi_pkg;

    localparam logic [7:0] SD_ADDR_DATA = 8'h60;
    localparam logic [7:0] SD_ADDR_CTRL = 8'h61;

    localparam int CTRL_REQ = 7;
    localparam int CTRL_CS  = 0;

    localparam int ST_GRANT = 7;
    localparam int ST_BUSY  = 6;

    localparam logic MISO_IDLE = 1'b1;

    function automatic logic [7:0] status_byte(input logic grant, input logic busy);
        logic [7:0] s;
        s           = 8'h00;
        s[ST_GRANT] = grant;
        s[ST_BUSY]  = busy;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avr_sdspi_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : avr_sdspi_regs_if
//  Brief    : AVR SPI pins plus SD-master request bus; master = register port
//  Revision : 1.0  initial release
// ============================================================================
interface avr_sdspi_regs_if;

    logic       spick;
    logic       spics_n;
    logic       spido;
    logic       spidi;
    logic       sd_req;
    logic       sd_grant;
    logic       sd_cs_n;
    logic       sd_start;
    logic [7:0] sd_wrdata;
    logic       sd_busy;
    logic [7:0] sd_rddata;

    modport master (
        input  spick, spics_n, spido, sd_grant, sd_busy, sd_rddata,
        output spidi, sd_req, sd_cs_n, sd_start, sd_wrdata
    );

    modport slave (
        output spick, spics_n, spido, sd_grant, sd_busy, sd_rddata,
        input  spidi, sd_req, sd_cs_n, sd_start, sd_wrdata
    );

endinterface
`default_nettype wire

// File: rtl/avr_spi_sync.sv
`default_nettype none
// ============================================================================
//  Module   : avr_spi_sync
//  Brief    : 2-flop synchronizer with optional registered rise/fall strobes
//  Revision : 1.0  initial release
// ============================================================================
module avr_spi_sync #(
    parameter logic IDLE     = 1'b0,
    parameter bit   EDGE_DET = 1'b1
) (
    input  wire logic fclk,
    input  wire logic rst,
    input  wire logic din,
    output logic      lvl,
    output logic      rise,
    output logic      fall
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_s1 <= IDLE;
            r_s2 <= IDLE;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    generate
        if (EDGE_DET) begin : g_edge
            logic r_s3;
            logic r_rise;
            logic r_fall;

            // lvl is taken from the third flop so it lines up with the strobes
            always_ff @(posedge fclk) begin
                if (rst) begin
                    r_s3   <= IDLE;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_s3   <= r_s2;
                    r_rise <= r_s2 & ~r_s3;
                    r_fall <= ~r_s2 & r_s3;
                end
            end

            assign lvl  = r_s3;
            assign rise = r_rise;
            assign fall = r_fall;
        end else begin : g_lvl
            assign lvl  = r_s2;
            assign rise = 1'b0;
            assign fall = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/avr_sdspi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : avr_sdspi_regs
//  Brief    : AVR slave-SPI register port issuing SD-card SPI byte requests
//  Revision : 1.0  initial release
// ============================================================================
module avr_sdspi_regs
    import avr_sdspi_pkg::*;
#(
    parameter logic [7:0] ADDR_DATA = SD_ADDR_DATA,
    parameter logic [7:0] ADDR_CTRL = SD_ADDR_CTRL
) (
    input  wire logic         fclk,
    input  wire logic         rst,
    avr_sdspi_regs_if.master  bus
);

    logic w_ck_rise, w_ck_fall, w_ck_unused_lvl;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_do_lvl, w_do_unused_rise, w_do_unused_fall;

    avr_spi_sync #(.IDLE(1'b0), .EDGE_DET(1'b1)) u_sync_ck (
        .fclk(fclk), .rst(rst), .din(bus.spick),
        .lvl(w_ck_unused_lvl), .rise(w_ck_rise), .fall(w_ck_fall)
    );

    avr_spi_sync #(.IDLE(1'b1), .EDGE_DET(1'b1)) u_sync_cs (
        .fclk(fclk), .rst(rst), .din(bus.spics_n),
        .lvl(w_cs_lvl), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    avr_spi_sync #(.IDLE(1'b0), .EDGE_DET(1'b0)) u_sync_do (
        .fclk(fclk), .rst(rst), .din(bus.spido),
        .lvl(w_do_lvl), .rise(w_do_unused_rise), .fall(w_do_unused_fall)
    );

    logic [7:0] r_shreg;
    logic [2:0] r_bitcnt;
    logic [7:0] r_addr;
    logic [7:0] r_txreg;
    logic [7:0] r_sd_wrdata;
    logic       r_sd_req;
    logic       r_sd_cs_n;
    logic       r_sd_start;

    logic       w_cs_edge;
    logic [7:0] w_byte;
    logic       w_byte_done;
    logic [7:0] w_rd_data;

    // A select edge in the same cycle as a clock rise drops that bit
    assign w_cs_edge   = w_cs_rise | w_cs_fall;
    assign w_byte      = {w_do_lvl, r_shreg[7:1]};
    assign w_byte_done = w_ck_rise & ~w_cs_edge & (r_bitcnt == 3'd7);

    always_comb begin
        w_rd_data = 8'hFF;
        if (r_addr == ADDR_DATA) begin
            w_rd_data = bus.sd_rddata;
        end else if (r_addr == ADDR_CTRL) begin
            w_rd_data = status_byte(bus.sd_grant, bus.sd_busy);
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_shreg     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_addr      <= 8'h00;
            r_txreg     <= 8'hFF;
            r_sd_wrdata <= 8'h00;
            r_sd_req    <= 1'b0;
            r_sd_cs_n   <= 1'b1;
            r_sd_start  <= 1'b0;
        end else begin
            r_sd_start <= 1'b0;

            if (w_cs_edge) begin
                r_bitcnt <= 3'd0;
            end else if (w_ck_rise) begin
                r_shreg  <= w_byte;
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_cs_fall) begin
                r_txreg <= w_rd_data;
            end else if (w_ck_fall && !w_cs_lvl) begin
                r_txreg <= {MISO_IDLE, r_txreg[7:1]};
            end

            if (w_byte_done) begin
                if (w_cs_lvl) begin
                    r_addr <= w_byte;
                end else if (r_addr == ADDR_DATA) begin
                    r_sd_wrdata <= w_byte;
                    r_sd_start  <= 1'b1;
                end else if (r_addr == ADDR_CTRL) begin
                    // Dropping the request always deselects the card
                    r_sd_req  <= w_byte[CTRL_REQ];
                    r_sd_cs_n <= w_byte[CTRL_REQ] ? w_byte[CTRL_CS] : 1'b1;
                end
            end
        end
    end

    assign bus.spidi     = r_txreg[0];
    assign bus.sd_req    = r_sd_req;
    assign bus.sd_cs_n   = r_sd_cs_n;
    assign bus.sd_start  = r_sd_start;
    assign bus.sd_wrdata = r_sd_wrdata;

endmodule
`default_nettype wire

// File: tb/tb_avr_sdspi_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avr_sdspi_regs
//  Brief    : Scoreboard bench driving AVR SPI traffic into avr_sdspi_regs
//  Revision : 1.0  initial release
// ============================================================================
module tb_avr_sdspi_regs;

    localparam int HALF = 6;

    logic fclk = 1'b0;
    logic rst  = 1'b1;

    always #5 fclk = ~fclk;

    avr_sdspi_regs_if bus();

    avr_sdspi_regs #(.ADDR_DATA(8'h60), .ADDR_CTRL(8'h61)) dut (
        .fclk(fclk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;

    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] got_rd[$];

    logic       m_req  = 1'b0;
    logic       m_cs_n = 1'b1;
    logic [7:0] dbuf[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge fclk);
        #1;
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a);
        if (a == 8'h60) return bus.sd_rddata;
        if (a == 8'h61) return {bus.sd_grant, bus.sd_busy, 6'b000000};
        return 8'hFF;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h60) begin
            exp_wr.push_back(d);
        end else if (a == 8'h61) begin
            m_req  = d[7];
            m_cs_n = d[7] ? d[0] : 1'b1;
        end
    endtask

    task automatic byte_xfer(input logic [7:0] d, input int nbits, output logic [7:0] r);
        r = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            bus.spido = d[i];
            cyc(HALF);
            r[i] = bus.spidi;
            bus.spick = 1'b1;
            cyc(HALF);
            bus.spick = 1'b0;
        end
    endtask

    // Address byte, then nb full data bytes from dbuf, then an optional partial byte
    task automatic txn(input logic [7:0] a, input int nb, input int tail);
        logic [7:0] r;
        logic [7:0] snap;
        cyc(HALF);
        byte_xfer(a, 8, r);
        cyc(HALF);
        bus.spics_n = 1'b0;
        cyc(10);
        snap = model_read(a);
        for (int i = 0; i < nb; i++) begin
            model_write(a, dbuf[i]);
            byte_xfer(dbuf[i], 8, r);
            exp_rd.push_back((i == 0) ? snap : 8'hFF);
            got_rd.push_back(r);
        end
        if (tail > 0) byte_xfer(8'($urandom), tail, r);
        cyc(HALF);
        bus.spics_n = 1'b1;
        cyc(10);
        chk("sd_req", 32'(bus.sd_req), 32'(m_req));
        chk("sd_cs_n", 32'(bus.sd_cs_n), 32'(m_cs_n));
    endtask

    // Scoreboard monitor: write pulses and received MISO bytes
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge fclk);
            if (prev_start) chk("sd_start_width", 32'(bus.sd_start), 32'd0);
            if (!rst && bus.sd_start) begin
                n_pulses++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sd_start unexpected pulse wrdata=%h, no pulse required", bus.sd_wrdata);
                end else begin
                    chk("sd_wrdata", 32'(bus.sd_wrdata), 32'(exp_wr.pop_front()));
                end
            end
            prev_start = bus.sd_start & ~rst;
            if (got_rd.size() > 0 && exp_rd.size() > 0)
                chk("miso_byte", 32'(got_rd.pop_front()), 32'(exp_rd.pop_front()));
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string      s;
        logic [7:0] r;
        logic [7:0] a;
        int         np;

        bus.spick     = 1'b0;
        bus.spics_n   = 1'b1;
        bus.spido     = 1'b0;
        bus.sd_grant  = 1'b0;
        bus.sd_busy   = 1'b0;
        bus.sd_rddata = 8'h00;
        rst = 1'b1;
        cyc(4);
        chk("rst_sd_req", 32'(bus.sd_req), 32'd0);
        chk("rst_sd_cs_n", 32'(bus.sd_cs_n), 32'd1);
        chk("rst_sd_start", 32'(bus.sd_start), 32'd0);
        chk("rst_sd_wrdata", 32'(bus.sd_wrdata), 32'h00);
        chk("rst_spidi", 32'(bus.spidi), 32'd1);
        rst = 1'b0;
        cyc(5);

        // Request without selecting, then read status back
        dbuf[0] = 8'h81;
        txn(8'h61, 1, 0);
        txn(8'h61, 1, 0);

        bus.sd_grant = 1'b1;
        bus.sd_busy  = 1'b1;
        txn(8'h61, 1, 0);
        bus.sd_grant = 1'b0;
        bus.sd_busy  = 1'b0;

        // Select the card and stream a string
        dbuf[0] = 8'h80;
        txn(8'h61, 1, 0);
        s = "AVR SEND\n";
        for (int i = 0; i < s.len(); i++) dbuf[i] = s[i];
        np = n_pulses;
        txn(8'h60, s.len(), 0);
        chk("string_pulses", 32'(n_pulses - np), 32'(s.len()));

        bus.sd_rddata = 8'h5A;
        dbuf[0] = 8'hFF;
        txn(8'h60, 1, 0);

        // Release rule
        dbuf[0] = 8'h01;
        txn(8'h61, 1, 0);
        dbuf[0] = 8'h00;
        txn(8'h61, 1, 0);

        // Partial data byte produces nothing
        np = n_pulses;
        txn(8'h60, 0, 5);
        chk("partial_no_start", 32'(n_pulses), 32'(np));

        // Reset in the middle of an address byte
        dbuf[0] = 8'h80;
        txn(8'h61, 1, 0);
        cyc(HALF);
        byte_xfer(8'h61, 4, r);
        rst = 1'b1;
        cyc(3);
        chk("mid_rst_sd_req", 32'(bus.sd_req), 32'd0);
        chk("mid_rst_sd_cs_n", 32'(bus.sd_cs_n), 32'd1);
        chk("mid_rst_sd_wrdata", 32'(bus.sd_wrdata), 32'h00);
        chk("mid_rst_spidi", 32'(bus.spidi), 32'd1);
        m_req  = 1'b0;
        m_cs_n = 1'b1;
        rst = 1'b0;
        cyc(5);
        dbuf[0] = 8'h80;
        txn(8'h61, 1, 0);

        dbuf[0] = 8'($urandom);
        txn(8'h33, 1, 0);

        // Randomized traffic
        for (int k = 0; k < 25; k++) begin
            bus.sd_rddata = 8'($urandom);
            bus.sd_grant  = 1'($urandom);
            bus.sd_busy   = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    a = 8'h60;
                2:       a = 8'h61;
                default: a = 8'($urandom);
            endcase
            for (int i = 0; i < 3; i++) dbuf[i] = 8'($urandom);
            txn(a, $urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end

        cyc(20);
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_drained", 32'(got_rd.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avr_sdspi_regs.md
# avr_sdspi_regs

Slave-side SPI register port that consumes the AVR's slave-SPI traffic and turns it into SD-card SPI access requests. Sits directly downstream of the AVR SPI pins, oversampling them in the `fclk` domain. It decodes address/data byte pairs, maintains the SD-access control register (request, card select), and issues byte-transfer starts to the shared SD SPI master. It returns grant, busy and received-byte status to the AVR.

## Interface
Parameters:
- `ADDR_DATA`, 8'h60: SD data register address
- `ADDR_CTRL`, 8'h61: SD control register address

Ports:
- `fclk`  in  1  system clock; one clock domain. All state changes on its rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `spick`  in  1  AVR SPI clock (async, idle low)
- `spics_n`  in  1  AVR select (async). High selects address phase, low selects data phase.
- `spido`  in  1  AVR MOSI (async), LSB first
- `spidi`  out  1  AVR MISO, LSB first
- `sd_req`  out  1  AVR requests the SD bus
- `sd_grant`  in  1  arbiter grants the SD bus to the AVR
- `sd_cs_n`  out  1  requested SD card select level
- `sd_start`  out  1  one-cycle pulse: send `sd_wrdata`
- `sd_wrdata`  out  8  byte to send to SD
- `sd_busy`  in  1  SD master transfer in progress
- `sd_rddata`  in  8  last byte received from SD

## Operation
- Input conditioning:
  - `spick`, `spics_n` and `spido` each pass through a 2-flop synchronizer.
  - `spick` additionally gets a third flop for rise/fall detection.
  - `spics_n` likewise gets rise/fall detection.
- Shift-in:
  - On each synchronized `spick` rise, shift `spido` into bit 7 of `shreg` and shift right, so the first bit lands in bit 0 after 8 bits.
  - Increment the 3-bit `bitcnt`. It wraps from 7 to 0.
  - The 8th bit completes a byte.
- Any `spics_n` edge clears `bitcnt`. A partial byte in progress is discarded and causes no strobe.
- Byte completed while `spics_n`=1: latch it into `addr`. No register side effects.
- `spics_n` falling edge: load `txreg` from the read mux for `addr`.
- Read mux:
  - `ADDR_DATA` returns `sd_rddata`.
  - `ADDR_CTRL` returns {`sd_grant`, `sd_busy`, 6'b0}.
  - Any other address returns 8'hFF.
- MISO:
  - `spidi` = `txreg[0]`.
  - On each synchronized `spick` fall while `spics_n`=0, shift `txreg` right, filling bit 7 with 1.
- Byte completed while `spics_n`=0, by address:
  - `ADDR_DATA`: `sd_wrdata` <= byte; `sd_start` pulses. The pulse happens even when `sd_grant`=0; the arbiter gates it.
  - `ADDR_CTRL`: `sd_req` <= bit7; `sd_cs_n` <= bit0. Other bits are ignored.
  - Any other address: ignored.
- Further bytes in the same `spics_n`-low window write the same `addr` again. Each such byte produces its own strobe.
- Release rule: writing `ADDR_CTRL` with bit7=0 forces `sd_cs_n` to 1, regardless of bit0.

## Timing
- Reset values: `sd_req`=0, `sd_cs_n`=1, `sd_start`=0, `sd_wrdata`=8'h00, `spidi`=1, `txreg`=8'hFF, `addr`=8'h00, `bitcnt`=0, all synchronizer flops=idle (`spick` 0, `spics_n` 1, `spido` 0).
- Reset mid-byte: the partial byte is discarded and no pulse is emitted.
- Input-to-edge latency: 3 `fclk` cycles from a pin edge to its internal edge strobe.
- Write side effects: registered, visible 1 cycle after the strobe.
  - `sd_start` is exactly 1 cycle high, 4 `fclk` cycles after the 8th raw `spick` rise.
- Read snapshot: `txreg` is captured in the cycle after the internal `spics_n` fall strobe.
  - Status changes after that point are not reflected until the next data phase.
- Constraint on the AVR side: `spick` high and low phases must each be ≥2 `fclk` periods. `spics_n` must be stable ≥2 `fclk` periods before the first `spick` rise.
- Simultaneous events: a `spics_n` edge strobe and a `spick` rise strobe in the same cycle is a protocol violation. In that case the `spics_n` edge wins: `bitcnt` is cleared and the bit is dropped.

## Structure
- Package `avr_sdspi_pkg`:
  - Register address constants.
  - Control bit positions: `CTRL_REQ`=7, `CTRL_CS`=0.
  - Status bit positions: `ST_GRANT`=7, `ST_BUSY`=6.
  - Idle MISO fill value.
- Sub-module `avr_spi_sync`: 2-flop synchronizer plus edge detector, outputs `lvl`/`rise`/`fall`. Instantiated 3 times; `spido` uses `lvl` only.
- Top module contains the shifter, bit counter, address latch, read mux and control registers.

## Test plan
- Reset, then write 8'h81 to addr 8'h61 LSB-first with `sd_grant`=0 -> `sd_req`=1, `sd_cs_n`=1. A subsequent read of addr 8'h61 returns 8'h00.
- Set `sd_grant`=1, `sd_busy`=1, then read addr 8'h61 -> 8'hC0.
- Write 8'h80 to 8'h61, then the bytes of "AVR SEND\n" to 8'h60 -> `sd_cs_n`=0, nine `sd_start` pulses of 1 cycle each, with `sd_wrdata` sequence 8'h41 ... 8'h0A.
- Set `sd_rddata`=8'h5A, write addr 8'h60 then toggle 8 clocks in the data phase -> the AVR receives 8'h5A LSB-first.
- Write 8'h01 to 8'h61 -> `sd_req`=0, `sd_cs_n`=1. Repeat with 8'h00 -> `sd_cs_n` still 1 (release forces deselect).
- Raise `spics_n` after 5 bits of a data byte to 8'h60 -> no `sd_start`. Assert `rst` mid-address-byte -> all outputs return to reset values and the next full transaction decodes correctly. Read of addr 8'h33 -> 8'hFF.
